// File: rtl/stream_demux1_2.sv
// 1-to-2 stream demultiplexer: routes whole packets to out0 or out1 with a registered output stage per port.
// Optional per-output delivered-packet counters are enabled by defining STREAM_DEMUX_STATS_EN.
module stream_demux1_2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_last,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_last,
  output logic             pkt_active
`ifdef STREAM_DEMUX_STATS_EN
  ,
  output logic [15:0]      pkt_cnt0,
  output logic [15:0]      pkt_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t           r_state;
  logic             r_vld0_p0;
  logic             r_vld1_p0;
  logic [WIDTH-1:0] r_data0_p0;
  logic [WIDTH-1:0] r_data1_p0;
  logic             r_last0_p0;
  logic             r_last1_p0;

  logic w_tgt;
  logic w_in_ready;
  logic w_xfer;

  // Destination follows sel only between packets; inside a packet the lock decides.
  always_comb begin
    w_tgt = sel;
    if (r_state == LOCK0) w_tgt = 1'b0;
    else if (r_state == LOCK1) w_tgt = 1'b1;
  end

  assign w_in_ready = rst_n && (w_tgt ? (!r_vld1_p0 || out1_ready)
                                      : (!r_vld0_p0 || out0_ready));
  assign w_xfer     = in_valid && w_in_ready;

  // Input -> output stage p0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_vld0_p0  <= 1'b0;
      r_vld1_p0  <= 1'b0;
      r_data0_p0 <= '0;
      r_data1_p0 <= '0;
      r_last0_p0 <= 1'b0;
      r_last1_p0 <= 1'b0;
    end else begin
      if (w_xfer) begin
        if (in_last)    r_state <= IDLE;
        else if (w_tgt) r_state <= LOCK1;
        else            r_state <= LOCK0;
      end

      if (w_xfer && !w_tgt) begin
        r_vld0_p0  <= 1'b1;
        r_data0_p0 <= in_data;
        r_last0_p0 <= in_last;
      end else if (r_vld0_p0 && out0_ready) begin
        r_vld0_p0  <= 1'b0;
      end

      if (w_xfer && w_tgt) begin
        r_vld1_p0  <= 1'b1;
        r_data1_p0 <= in_data;
        r_last1_p0 <= in_last;
      end else if (r_vld1_p0 && out1_ready) begin
        r_vld1_p0  <= 1'b0;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out0_valid = r_vld0_p0;
  assign out0_data  = r_data0_p0;
  assign out0_last  = r_last0_p0;
  assign out1_valid = r_vld1_p0;
  assign out1_data  = r_data1_p0;
  assign out1_last  = r_last1_p0;
  assign pkt_active = (r_state != IDLE);

`ifdef STREAM_DEMUX_STATS_EN
  logic [15:0] r_cnt0;
  logic [15:0] r_cnt1;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Delivered-packet counters, bumped on the handshake of a last beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (r_vld0_p0 && out0_ready && r_last0_p0) r_cnt0 <= sat_inc(r_cnt0);
      if (r_vld1_p0 && out1_ready && r_last1_p0) r_cnt1 <= sat_inc(r_cnt1);
    end
  end

  assign pkt_cnt0 = r_cnt0;
  assign pkt_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_stream_demux1_2.sv
// Scoreboard bench for stream_demux1_2: expected beats are queued per output at input transfer and popped on output handshake.
module tb_stream_demux1_2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       sel;
  logic       out0_valid, out0_ready, out0_last;
  logic [7:0] out0_data;
  logic       out1_valid, out1_ready, out1_last;
  logic [7:0] out1_data;
  logic       pkt_active;
`ifdef STREAM_DEMUX_STATS_EN
  logic [15:0] pkt_cnt0, pkt_cnt1;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int mdl_lock = -1;
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  stream_demux1_2 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last), .sel(sel),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data), .out0_last(out0_last),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data), .out1_last(out1_last),
    .pkt_active(pkt_active)
`ifdef STREAM_DEMUX_STATS_EN
    , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; leaves in_valid high so beats can go back-to-back.
  task automatic send(input logic [7:0] d, input logic l, input logic s);
    int n = 0;
    int tgt;
    in_valid = 1'b1; in_data = d; in_last = l; sel = s;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    end else begin
      tgt = (mdl_lock < 0) ? int'(s) : mdl_lock;
      if (tgt == 0) q0.push_back({l, d});
      else          q1.push_back({l, d});
      mdl_lock = l ? -1 : tgt;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    q0.delete(); q1.delete();
    mdl_lock = -1;
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n === 1'b1) begin
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) chk("out0_unexpected", {31'b0, out0_valid}, 32'd0);
        else begin
          e = q0.pop_front();
          chk("out0_data", {24'b0, out0_data}, {24'b0, e[7:0]});
          chk("out0_last", {31'b0, out0_last}, {31'b0, e[8]});
        end
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) chk("out1_unexpected", {31'b0, out1_valid}, 32'd0);
        else begin
          e = q1.pop_front();
          chk("out1_data", {24'b0, out1_data}, {24'b0, e[7:0]});
          chk("out1_last", {31'b0, out1_last}, {31'b0, e[8]});
        end
      end
    end
  end

  initial begin
    in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b0; sel = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    do_reset(2);
    chk("rst_in_ready",   {31'b0, in_ready},   32'd0);
    chk("rst_out0_valid", {31'b0, out0_valid}, 32'd0);
    chk("rst_out1_valid", {31'b0, out1_valid}, 32'd0);
    chk("rst_out0_data",  {24'b0, out0_data},  32'h00);
    chk("rst_out1_data",  {24'b0, out1_data},  32'h00);
    chk("rst_pkt_active", {31'b0, pkt_active}, 32'd0);
    idle();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // single-beat routing, consecutive clocks
    send(8'h11, 1'b1, 1'b0);
    chk("sb_out0_valid", {31'b0, out0_valid}, 32'd1);
    chk("sb_out0_data",  {24'b0, out0_data},  32'h11);
    chk("sb_pkt_active", {31'b0, pkt_active}, 32'd0);
    send(8'h22, 1'b1, 1'b1);
    chk("sb_out1_valid", {31'b0, out1_valid}, 32'd1);
    chk("sb_out1_data",  {24'b0, out1_data},  32'h22);
    chk("sb_pkt_active2", {31'b0, pkt_active}, 32'd0);
    idle();
    repeat (2) @(posedge clk);
    #1;

    // packet lock: sel changes after the first beat are ignored
    send(8'h01, 1'b0, 1'b1);
    chk("lk_active_on", {31'b0, pkt_active}, 32'd1);
    send(8'h02, 1'b0, 1'b0);
    send(8'h03, 1'b1, 1'b0);
    chk("lk_active_off", {31'b0, pkt_active}, 32'd0);
    idle();
    repeat (2) @(posedge clk);
    #1;

    // full-throughput packet to out0
    for (int i = 0; i < 4; i++) send(8'h40 + 8'(i), (i == 3), 1'b0);
    idle();
    repeat (2) @(posedge clk);
    #1;

    // backpressure on out0
    out0_ready = 1'b0;
    send(8'h5A, 1'b1, 1'b0);
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out0_valid", {31'b0, out0_valid}, 32'd1);
      chk("bp_out0_data",  {24'b0, out0_data},  32'h5A);
    end
    in_valid = 1'b1; in_data = 8'h66; in_last = 1'b1; sel = 1'b0;
    @(negedge clk);
    chk("bp_in_ready_blocked", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    send(8'h77, 1'b1, 1'b1);
    chk("bp_out1_valid", {31'b0, out1_valid}, 32'd1);
    chk("bp_out0_hold",  {24'b0, out0_data},  32'h5A);
    idle();
    @(posedge clk); #1;
    out0_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // reset in the middle of an open packet
    send(8'hA1, 1'b0, 1'b0);
    send(8'hA2, 1'b0, 1'b0);
    idle();
    chk("mr_active_pre", {31'b0, pkt_active}, 32'd1);
    do_reset(1);
    rst_n = 1'b1;
    chk("mr_pkt_active", {31'b0, pkt_active}, 32'd0);
    chk("mr_out0_valid", {31'b0, out0_valid}, 32'd0);
    chk("mr_out1_valid", {31'b0, out1_valid}, 32'd0);
    send(8'hB1, 1'b1, 1'b1);
    chk("mr_out1_valid_post", {31'b0, out1_valid}, 32'd1);
    chk("mr_out0_valid_post", {31'b0, out0_valid}, 32'd0);
    idle();
    repeat (3) @(posedge clk);
    #1;

`ifdef STREAM_DEMUX_STATS_EN
    do_reset(1);
    rst_n = 1'b1;
    send(8'hC0, 1'b1, 1'b0);
    send(8'hC1, 1'b0, 1'b0);
    send(8'hC2, 1'b1, 1'b1);
    send(8'hC3, 1'b1, 1'b0);
    send(8'hC4, 1'b1, 1'b1);
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("st_pkt_cnt0", {16'b0, pkt_cnt0}, 32'd3);
    chk("st_pkt_cnt1", {16'b0, pkt_cnt1}, 32'd1);
`endif

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/stream_demux1_2.md
Name: stream_demux1_2

Overview:
- 1-to-2 streaming demultiplexer: the routing counterpart of the 2:1 mux.
- Takes one valid/ready input stream with 'last' framing and steers each packet to out0 or out1.
- The destination is selected by 'sel' on the first beat of a packet and held for the whole packet.
- Each output has a single-entry registered stage, so the block sits between a stream source and two independent consumers at full throughput.

Parameters:
WIDTH, 8, data width of input and both outputs in bits

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept input beat
in_data  input  WIDTH  input beat data
in_last  input  1  final beat of packet
sel  input  1  destination for packet (0 -> out0, 1 -> out1); sampled on first beat only
out0_valid  output  1  out0 beat valid
out0_ready  input  1  out0 consumer accepts
out0_data  output  WIDTH  out0 beat data
out0_last  output  1  out0 final beat of packet
out1_valid  output  1  out1 beat valid
out1_ready  input  1  out1 consumer accepts
out1_data  output  WIDTH  out1 beat data
out1_last  output  1  out1 final beat of packet
pkt_active  output  1  high while a packet is open (state LOCK0/LOCK1)

Behaviour:
- Reset: one clock, rst_n is synchronous and active-low. While rst_n=0 at a clock edge:
  - state <= IDLE.
  - out0_valid, out1_valid, out0_last and out1_last <= 0; out0_data and out1_data <= 0.
  - in_ready is forced to 0 combinationally while rst_n=0.
  - pkt_active=0.
- Reset mid-packet discards the open packet and any buffered beats; nothing is replayed.
- State machine, tgt = target output:
  - IDLE: tgt = sel. On transfer with in_last=0 -> LOCK{sel}; with in_last=1 (single-beat packet) stay IDLE.
  - LOCK0 / LOCK1: tgt fixed at 0 / 1, sel ignored. A transfer with in_last=1 -> IDLE; otherwise stay.
- Input acceptance:
  - in_ready = rst_n && (!outN_valid || outN_ready) for N = tgt. Combinational, no dependence on in_valid.
  - Transfer occurs when in_valid && in_ready.
- Output stage N: on transfer to N, outN_valid<=1 and outN_data/outN_last <= in_data/in_last.
- Output drain: else if outN_valid && outN_ready, outN_valid<=0; data and last hold their value.
- Latency and throughput: accepted beat appears on the output the next cycle. Simultaneous drain and load sustain 1 beat/clock.
- While outN_valid=1 && outN_ready=0, outN_data and outN_last are stable.
- Non-target output keeps draining independently; its ready never affects in_ready.
- Ordering: beats within a packet are never reordered or split across outputs. Back-to-back packets to different outputs may be accepted on consecutive cycles.
- in_valid may drop mid-packet. The lock holds indefinitely until the last beat.
- pkt_active = (state != IDLE).

Optional Feature:
Macro STREAM_DEMUX_STATS_EN.
- Defined:
  - Adds outputs pkt_cnt0 and pkt_cnt1, 16 bits each.
  - Each counts completed packets delivered to that output, incremented when outN_valid && outN_ready && outN_last.
  - Counters saturate at 16'hFFFF and reset to 0 on rst_n=0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset: hold rst_n=0 for 2 clk with in_valid=1, in_data=8'hAA -> in_ready=0, out0_valid=out1_valid=0, data 8'h00, pkt_active=0. After release, nothing is emitted.
- Single-beat routing: out0/1_ready=1; beats 8'h11 (sel=0, last=1) then 8'h22 (sel=1, last=1) on consecutive clocks -> out0 shows 8'h11 one cycle later, out1 shows 8'h22 the cycle after. pkt_active stays 0.
- Packet lock: 3-beat packet 8'h01, 8'h02, 8'h03 (last on 8'h03) with sel=1, 0, 0 -> all three beats appear on out1 in order; out0_valid stays 0. pkt_active=1 after beat 1 and 0 after beat 3.
- Backpressure: out0_ready=0 with 8'h5A (sel=0, last=1) accepted -> out0_valid=1 and data 8'h5A held stable ≥5 cycles. Next beat for out0 sees in_ready=0. A beat with sel=1 is accepted and emitted on out1 meanwhile.
- Reset mid-packet: send 2 beats of a sel=0 packet without last, pulse rst_n=0 for 1 clk -> state IDLE, outputs invalid. A following beat with sel=1 routes to out1.
- Stats (STREAM_DEMUX_STATS_EN): deliver 3 packets to out0 and 1 to out1 -> pkt_cnt0=3, pkt_cnt1=1. Preloaded near saturation, pkt_cnt0 stays at 16'hFFFF.
